// File: rtl/wall_tracker_if.sv
// Signal bundle between the wall tracker and its neighbours: generator coordinates,
// load/clear/scan controls, raster position and the tracker's status outputs.
interface wall_tracker_if;
    logic [10:0] wall_x;
    logic [10:0] wall_y;
    logic        load_req;
    logic        clear;
    logic        check;
    logic [10:0] head_x;
    logic [10:0] head_y;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        wall_pixel;
    logic        busy;
    logic        load_ack;
    logic        load_err;
    logic        done;
    logic        hit;
    logic [3:0]  wall_count;
    logic        full;

    modport master (
        output wall_x, wall_y, load_req, clear, check, head_x, head_y, pix_x, pix_y,
        input  wall_pixel, busy, load_ack, load_err, done, hit, wall_count, full
    );

    modport slave (
        input  wall_x, wall_y, load_req, clear, check, head_x, head_y, pix_x, pix_y,
        output wall_pixel, busy, load_ack, load_err, done, hit, wall_count, full
    );
endinterface

// File: rtl/wall_tracker.sv
// Stores up to NUM_WALLS square walls from the wall generator; provides a registered
// per-pixel wall flag for the renderer and a fixed-length head collision scan.
module wall_tracker #(
    parameter int NUM_WALLS = 8,
    parameter int WALL_SIZE = 16,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480
) (
    input logic           pixel_clk,
    input logic           reset,
    wall_tracker_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;

    localparam logic [11:0] SIZE_M1  = 12'(WALL_SIZE - 1);
    localparam logic [11:0] MAX_X    = 12'(SCREEN_W - WALL_SIZE);
    localparam logic [11:0] MAX_Y    = 12'(SCREEN_H - WALL_SIZE);
    localparam logic [3:0]  LAST_IDX = 4'(NUM_WALLS - 1);
    localparam logic [3:0]  NUM_W4   = 4'(NUM_WALLS);

    logic [1:0]           state_q, state_d;
    logic [NUM_WALLS-1:0] valid_q, valid_d;
    logic [10:0]          x_q [NUM_WALLS];
    logic [10:0]          x_d [NUM_WALLS];
    logic [10:0]          y_q [NUM_WALLS];
    logic [10:0]          y_d [NUM_WALLS];
    logic [3:0]           count_q, count_d;
    logic [3:0]           idx_q, idx_d;
    logic [10:0]          head_x_q, head_x_d;
    logic [10:0]          head_y_q, head_y_d;
    logic                 hit_q, hit_d;
    logic                 done_q, done_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 wall_pixel_q, wall_pixel_d;
    logic                 full_w;
    logic                 scan_hit;

    // Widened to 12 bits so x+WALL_SIZE-1 cannot wrap near the 11-bit limit.
    function automatic logic in_wall(input logic [10:0] px, input logic [10:0] py,
                                     input logic [10:0] wx, input logic [10:0] wy);
        logic [11:0] px12, py12, wx12, wy12;
        px12 = {1'b0, px};
        py12 = {1'b0, py};
        wx12 = {1'b0, wx};
        wy12 = {1'b0, wy};
        return (px12 >= wx12) && (px12 <= wx12 + SIZE_M1) &&
               (py12 >= wy12) && (py12 <= wy12 + SIZE_M1);
    endfunction

    assign full_w = (count_q == NUM_W4);

    always_comb begin
        wall_pixel_d = 1'b0;
        for (int unsigned i = 0; i < NUM_WALLS; i++) begin
            if (valid_q[i] && in_wall(bus.pix_x, bus.pix_y, x_q[i], y_q[i]))
                wall_pixel_d = 1'b1;
        end
    end

    always_comb begin
        scan_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_WALLS; i++) begin
            if (4'(i) == idx_q && valid_q[i] && in_wall(head_x_q, head_y_q, x_q[i], y_q[i]))
                scan_hit = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        x_d      = x_q;
        y_d      = y_q;
        count_d  = count_q;
        idx_d    = idx_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        hit_d    = hit_q;
        done_d   = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;

        if (bus.clear) begin
            state_d = S_IDLE;
            valid_d = '0;
            count_d = '0;
            hit_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.check) begin
                        state_d  = S_SCAN;
                        head_x_d = bus.head_x;
                        head_y_d = bus.head_y;
                        idx_d    = '0;
                        hit_d    = 1'b0;
                    end else if (bus.load_req) begin
                        if (full_w) err_d   = 1'b1;
                        else        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.wall_x != '0 && bus.wall_y != '0) begin
                        state_d = S_IDLE;
                        if ({1'b0, bus.wall_x} <= MAX_X && {1'b0, bus.wall_y} <= MAX_Y) begin
                            for (int unsigned i = 0; i < NUM_WALLS; i++) begin
                                if (4'(i) == count_q) begin
                                    valid_d[i] = 1'b1;
                                    x_d[i]     = bus.wall_x;
                                    y_d[i]     = bus.wall_y;
                                end
                            end
                            count_d = count_q + 4'd1;
                            ack_d   = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (scan_hit) hit_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            head_x_q     <= '0;
            head_y_q     <= '0;
            hit_q        <= 1'b0;
            done_q       <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            wall_pixel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            head_x_q     <= head_x_d;
            head_y_q     <= head_y_d;
            hit_q        <= hit_d;
            done_q       <= done_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            wall_pixel_q <= wall_pixel_d;
        end
    end

    // Coordinates are qualified by valid_q, so they need no reset.
    always_ff @(posedge pixel_clk) begin
        x_q <= x_d;
        y_q <= y_d;
    end

    assign bus.wall_pixel = wall_pixel_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.load_ack   = ack_q;
    assign bus.load_err   = err_q;
    assign bus.done       = done_q;
    assign bus.hit        = hit_q;
    assign bus.wall_count = count_q;
    assign bus.full       = full_w;
endmodule

// File: tb/tb_wall_tracker.sv
// Directed bench for wall_tracker: pixel vectors from a table plus hand-written
// load, scan, full, range-reject, clear-abort and busy-ignore sequences.
module tb_wall_tracker;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    wall_tracker_if bus ();

    wall_tracker #(
        .NUM_WALLS(8),
        .WALL_SIZE(16),
        .SCREEN_W (640),
        .SCREEN_H (480)
    ) dut (
        .pixel_clk(clk),
        .reset    (rst),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [10:0] px;
        logic [10:0] py;
        logic        exp_pix;
    } pix_vec_t;

    pix_vec_t pix_tab [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [10:0] x, input logic [10:0] y,
                           input logic exp_ack, input int exp_count);
        bus.wall_x   = x;
        bus.wall_y   = y;
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        chk("load_busy", 32'(bus.busy), 1);
        tick();
        chk("load_ack", 32'(bus.load_ack), 32'(exp_ack));
        chk("load_err", 32'(bus.load_err), 32'(!exp_ack));
        chk("load_count", 32'(bus.wall_count), 32'(exp_count));
        chk("load_idle", 32'(bus.busy), 0);
    endtask

    // with_load: also raise load_req on the check cycle and once mid-scan
    task automatic do_scan(input logic [10:0] hx, input logic [10:0] hy,
                           input logic exp_hit, input logic with_load);
        bus.head_x   = hx;
        bus.head_y   = hy;
        bus.check    = 1'b1;
        bus.load_req = with_load;
        tick();
        bus.check    = 1'b0;
        bus.load_req = 1'b0;
        chk("scan_busy", 32'(bus.busy), 1);
        chk("scan_hit_cleared", 32'(bus.hit), 0);
        chk("scan_done_early", 32'(bus.done), 0);
        for (int k = 2; k <= 8; k++) begin
            bus.load_req = with_load && (k == 3);
            tick();
            chk("scan_done_early", 32'(bus.done), 0);
            chk("scan_no_ack", 32'(bus.load_ack), 0);
        end
        bus.load_req = 1'b0;
        tick();
        chk("scan_done", 32'(bus.done), 1);
        chk("scan_hit", 32'(bus.hit), 32'(exp_hit));
        chk("scan_end_idle", 32'(bus.busy), 0);
        tick();
        chk("scan_done_pulse", 32'(bus.done), 0);
        chk("scan_hit_held", 32'(bus.hit), 32'(exp_hit));
        chk("scan_no_ack", 32'(bus.load_ack), 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        pix_tab[0] = '{11'd624, 11'd464, 1'b1};
        pix_tab[1] = '{11'd639, 11'd479, 1'b1};
        pix_tab[2] = '{11'd623, 11'd470, 1'b0};
        pix_tab[3] = '{11'd630, 11'd463, 1'b0};
        pix_tab[4] = '{11'd100, 11'd200, 1'b1};
        pix_tab[5] = '{11'd115, 11'd215, 1'b1};
        pix_tab[6] = '{11'd99,  11'd200, 1'b0};
        pix_tab[7] = '{11'd116, 11'd200, 1'b0};
        pix_tab[8] = '{11'd100, 11'd216, 1'b0};
        pix_tab[9] = '{11'd0,   11'd0,   1'b0};

        bus.wall_x   = '0;
        bus.wall_y   = '0;
        bus.load_req = 1'b0;
        bus.clear    = 1'b0;
        bus.check    = 1'b0;
        bus.head_x   = '0;
        bus.head_y   = '0;
        bus.pix_x    = '0;
        bus.pix_y    = '0;
        rst          = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_count", 32'(bus.wall_count), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_hit", 32'(bus.hit), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ack", 32'(bus.load_ack), 0);
        chk("rst_err", 32'(bus.load_err), 0);
        chk("rst_pix", 32'(bus.wall_pixel), 0);

        // first wall, then visible to rendering on the next cycle
        do_load(11'd100, 11'd200, 1'b1, 1);
        bus.pix_x = 11'd100;
        bus.pix_y = 11'd200;
        tick();
        chk("pix_new_wall", 32'(bus.wall_pixel), 1);
        bus.pix_x = 11'd99;
        tick();
        chk("pix_left_edge", 32'(bus.wall_pixel), 0);
        bus.pix_x = 11'd116;
        tick();
        chk("pix_right_edge", 32'(bus.wall_pixel), 0);

        do_scan(11'd115, 11'd215, 1'b1, 1'b0);
        do_scan(11'd116, 11'd215, 1'b0, 1'b0);

        // fill to capacity, then one more is rejected immediately
        for (int i = 0; i < 7; i++)
            do_load(11'(20 + 40 * i), 11'd20, 1'b1, i + 2);
        chk("full_set", 32'(bus.full), 1);
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        chk("full_err", 32'(bus.load_err), 1);
        chk("full_no_ack", 32'(bus.load_ack), 0);
        chk("full_busy", 32'(bus.busy), 0);
        chk("full_count", 32'(bus.wall_count), 8);
        tick();
        chk("full_err_pulse", 32'(bus.load_err), 0);

        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clr_count", 32'(bus.wall_count), 0);
        chk("clr_full", 32'(bus.full), 0);
        chk("clr_busy", 32'(bus.busy), 0);
        bus.pix_x = 11'd100;
        bus.pix_y = 11'd200;
        tick();
        chk("clr_pix", 32'(bus.wall_pixel), 0);

        // range limits: 624/464 is the last legal origin
        do_load(11'd625, 11'd50, 1'b0, 0);
        do_load(11'd50, 11'd465, 1'b0, 0);
        do_load(11'd624, 11'd464, 1'b1, 1);
        do_load(11'd100, 11'd200, 1'b1, 2);

        foreach (pix_tab[i]) begin
            bus.pix_x = pix_tab[i].px;
            bus.pix_y = pix_tab[i].py;
            tick();
            chk($sformatf("pix_tab[%0d]", i), 32'(bus.wall_pixel), 32'(pix_tab[i].exp_pix));
        end

        // clear aborts a scan that would otherwise hit
        bus.head_x = 11'd100;
        bus.head_y = 11'd200;
        bus.check  = 1'b1;
        tick();
        bus.check = 1'b0;
        tick();
        tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_hit", 32'(bus.hit), 0);
        chk("abort_count", 32'(bus.wall_count), 0);
        chk("abort_done", 32'(bus.done), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("abort_no_done", 32'(bus.done), 0);
        end
        do_scan(11'd100, 11'd200, 1'b0, 1'b0);

        // concurrent check+load_req: load dropped, mid-scan load_req ignored
        do_load(11'd100, 11'd200, 1'b1, 1);
        bus.wall_x = 11'd300;
        bus.wall_y = 11'd300;
        do_scan(11'd105, 11'd205, 1'b1, 1'b1);
        chk("drop_count", 32'(bus.wall_count), 1);

        // LOAD waits while the generator is still zero
        bus.wall_x   = '0;
        bus.wall_y   = '0;
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wait_busy", 32'(bus.busy), 1);
            chk("wait_no_ack", 32'(bus.load_ack), 0);
        end
        bus.wall_x = 11'd40;
        tick();
        chk("wait_half_busy", 32'(bus.busy), 1);
        chk("wait_half_no_ack", 32'(bus.load_ack), 0);
        bus.wall_y = 11'd40;
        tick();
        chk("wait_ack", 32'(bus.load_ack), 1);
        chk("wait_count", 32'(bus.wall_count), 2);
        do_scan(11'd45, 11'd45, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wall_tracker.md
# wall_tracker

Consumer side of the wall generator: captures the random wall coordinates the generator produces and stores up to NUM_WALLS square walls. It answers two questions for the rest of the game. The first is a per-pixel "is this raster pixel wall?" flag for the VGA renderer. The second is a multi-cycle "did the player head hit a wall?" check for game logic. It sits between the wall generator (x/y outputs) and the renderer and game-state controller, all on pixel_clk.

## Interface
- NUM_WALLS, 8: wall entries stored (1..15).
- WALL_SIZE, 16: wall square side in pixels.
- SCREEN_W, 640: visible width in pixels.
- SCREEN_H, 480: visible height in pixels.

- pixel_clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- wall_x  in  11  generator x coordinate (0 = not yet set).
- wall_y  in  11  generator y coordinate (0 = not yet set).
- load_req  in  1  one-cycle pulse: store the next valid generator position.
- clear  in  1  one-cycle pulse: invalidate all entries.
- check  in  1  one-cycle pulse: start a collision scan against head_x/head_y.
- head_x  in  11  player head x; sampled on the check cycle.
- head_y  in  11  player head y; sampled on the check cycle.
- pix_x  in  11  current raster x.
- pix_y  in  11  current raster y.
- wall_pixel  out  1  registered; 1 when (pix_x, pix_y) of the previous cycle lies inside any valid wall.
- busy  out  1  FSM not in IDLE.
- load_ack  out  1  one-cycle pulse: entry written.
- load_err  out  1  one-cycle pulse: load rejected.
- done  out  1  one-cycle pulse: scan complete, hit valid.
- hit  out  1  scan result; held until the next check, clear, or reset.
- wall_count  out  4  number of valid entries.
- full  out  1  wall_count == NUM_WALLS.

## Operation
- Storage: NUM_WALLS entries of {valid, x[10:0], y[10:0]}. Entries are filled in order at index wall_count.
- Wall region for entry i: x_i ≤ px ≤ x_i+WALL_SIZE−1 and y_i ≤ py ≤ y_i+WALL_SIZE−1. Comparisons are unsigned, 12-bit internally so there is no wrap.
- FSM states: IDLE, LOAD, SCAN.
- IDLE:
  - check → SCAN. Latch head_x/head_y, zero the scan index, clear hit.
  - Otherwise load_req with full=1 → load_err pulse, stay in IDLE.
  - Otherwise load_req → LOAD.
  - check has priority over load_req on the same cycle; the load_req is dropped.
- LOAD waits for wall_x≠0 and wall_y≠0, then:
  - If wall_x ≤ SCREEN_W−WALL_SIZE and wall_y ≤ SCREEN_H−WALL_SIZE: write the entry, set valid, increment wall_count, pulse load_ack, go to IDLE.
  - Otherwise pulse load_err, leave the entry unchanged, go to IDLE.
- Duplicate or overlapping walls are accepted.
- SCAN:
  - Examine one entry per cycle, index 0..NUM_WALLS−1.
  - A valid entry containing the head sets hit, which is sticky within the scan.
  - After the last index: pulse done, go to IDLE.
  - Invalid entries are skipped but still consume their cycle, so scan length is fixed.
- clear:
  - Has highest priority in any state.
  - Zeroes all valid bits, wall_count, and hit, and sends the FSM to IDLE.
  - An aborted scan never pulses done.
  - An aborted load never pulses load_ack or load_err.
- load_req and check arriving while busy=1 are ignored.
- Rendering path runs every cycle, independent of the FSM. It is a parallel compare of pix_x/pix_y against all valid entries, registered once.
- Reset (and clear for the relevant fields): wall_pixel, busy, load_ack, load_err, done, hit, full = 0; wall_count = 0; all valid bits 0; FSM = IDLE.

## Timing
- load_req at cycle T (IDLE, not full) → LOAD from T+1. With the generator already holding nonzero values, load_ack and the updated wall_count and full are visible at T+2.
- LOAD waits indefinitely while the generator outputs 0; busy stays high during the wait.
- check at cycle T → SCAN indices examined on cycles T+1..T+NUM_WALLS. done=1 and the final hit are visible at T+NUM_WALLS+1, which is 9 cycles for the defaults.
- A new entry is visible to wall_pixel in the cycle after its load_ack.
- wall_pixel latency: exactly 1 cycle from pix_x/pix_y.
- clear at T → all cleared values are visible at T+1.
- A check issued in the cycle after load_ack sees the new entry.

## Test plan
- Reset, then load (wall_x=100, wall_y=200) → load_ack at T+2, wall_count=1. Drive pix (100,200) → wall_pixel=1 next cycle. Drive pix (99,200) and (116,200) → wall_pixel=0 next cycle.
- Check with head (115,215) → done at T+9 with hit=1. Check with head (116,215) → done at T+9 with hit=0.
- Load 8 walls → full=1. A 9th load_req → load_err one cycle later, wall_count stays 8.
- Load wall_x=625 (> 624), wall_y=50 → load_err, wall_count unchanged, no load_ack. Load wall_x=624, wall_y=464 → accepted.
- Start a check, assert clear 3 cycles later → no done, hit=0, wall_count=0, busy=0 next cycle. A subsequent check returns hit=0.
- Assert check and load_req in the same IDLE cycle → scan runs and the load is dropped (wall_count unchanged). A load_req during the scan is ignored.
